ara_exit_ctrl: RTL and testbench

End-of-computation and runtime-measurement controller for the Ara test harness.
- Accepts tohost writes from the host-interface path and decodes exit requests.
- Drains the vector engine until idle or until a timeout expires.
- Sequences the packed exit word seen by the testbench: bit 0 is the done flag, bits 63:1 are the exit code.
- Owns the cycle counter that produces the hardware runtime figure.

---
 rtl/ara_exit_ctrl.sv | 105 ++++++++++
 tb/tb_ara_exit_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ara_exit_ctrl.sv
// Exit controller for the Ara harness: decodes tohost exit requests, drains the
// vector engine (idle or timeout), publishes the packed exit word and measures runtime.
module ara_exit_ctrl #(
  parameter int unsigned DrainTimeout = 1024,
  parameter int unsigned CntWidth     = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tohost_valid_i,
  input  logic [63:0]         tohost_data_i,
  output logic                tohost_ready_o,
  input  logic                cnt_start_i,
  input  logic                cnt_stop_i,
  input  logic                ara_idle_i,
  output logic [63:0]         exit_o,
  output logic                timeout_o,
  output logic [CntWidth-1:0] runtime_o,
  output logic                runtime_valid_o
);

  localparam int DW = $clog2(DrainTimeout + 1);

  typedef enum logic [1:0] {RUN, DRAIN, EXIT} state_e;

  state_e                state, state_nxt;
  logic   [62:0]         code;
  logic   [DW-1:0]       drain_cnt;
  logic                  idle_prev;
  logic                  req, idle_done, tmo_hit, to_exit, freeze;
  logic   [CntWidth-1:0] cnt, cnt_inc;
  logic                  active;

  assign tohost_ready_o = (state == RUN);
  assign req            = tohost_valid_i & tohost_ready_o & tohost_data_i[0];
  assign idle_done      = ara_idle_i & idle_prev;
  assign tmo_hit        = (drain_cnt == DW'(DrainTimeout - 1));
  assign to_exit        = (state == DRAIN) & (idle_done | tmo_hit);
  assign freeze         = (state == EXIT) | to_exit;
  assign cnt_inc        = (&cnt) ? cnt : cnt + CntWidth'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (req) state_nxt = DRAIN;
      DRAIN:   if (idle_done | tmo_hit) state_nxt = EXIT;
      EXIT:    state_nxt = EXIT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= RUN;
    else         state <= state_nxt;
  end

  // idle_prev remembers whether the previous DRAIN cycle was idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code      <= '0;
      drain_cnt <= '0;
      idle_prev <= 1'b0;
      exit_o    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (req) begin
        code      <= tohost_data_i[63:1];
        drain_cnt <= '0;
        idle_prev <= 1'b0;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DW'(1);
        idle_prev <= ara_idle_i;
      end
      if (to_exit) begin
        exit_o    <= {code, 1'b1};
        timeout_o <= ~idle_done;
      end
    end
  end

  // Runtime measurement; latched value is counter+1 so start@t0/stop@t1 gives t1-t0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt             <= '0;
      active          <= 1'b0;
      runtime_o       <= '0;
      runtime_valid_o <= 1'b0;
    end else if (freeze) begin
      active <= 1'b0;
    end else if (cnt_start_i) begin
      if (active && cnt_stop_i) begin
        runtime_o       <= cnt_inc;
        runtime_valid_o <= 1'b1;
      end
      cnt    <= '0;
      active <= 1'b1;
    end else if (cnt_stop_i && active) begin
      runtime_o       <= cnt_inc;
      runtime_valid_o <= 1'b1;
      active          <= 1'b0;
    end else if (active) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_ara_exit_ctrl.sv
// Bench for ara_exit_ctrl: table of exit scenarios plus hand-written runtime and reset sequences.
module tb_ara_exit_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        tohost_valid;
  logic [63:0] tohost_data;
  logic        tohost_ready;
  logic        cnt_start, cnt_stop, ara_idle;
  logic [63:0] exit_w;
  logic        timeout;
  logic [63:0] runtime;
  logic        runtime_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ara_exit_ctrl #(.DrainTimeout(16), .CntWidth(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tohost_valid_i(tohost_valid), .tohost_data_i(tohost_data), .tohost_ready_o(tohost_ready),
    .cnt_start_i(cnt_start), .cnt_stop_i(cnt_stop), .ara_idle_i(ara_idle),
    .exit_o(exit_w), .timeout_o(timeout), .runtime_o(runtime), .runtime_valid_o(runtime_valid)
  );

  typedef struct {
    logic        pre;
    logic [63:0] data;
    logic [15:0] mask;
    int          cycles;
    logic        tmo;
  } vec_t;

  typedef struct {
    logic [63:0] exit_word;
    logic        tmo;
    int          cycles;
  } exp_t;

  vec_t        vecs[7];
  exp_t        sb[$];
  logic [63:0] rt_sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tohost_valid = 1'b0; tohost_data = '0;
    cnt_start = 1'b0; cnt_stop = 1'b0; ara_idle = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse(input logic s, input logic p);
    cnt_start = s; cnt_stop = p;
    step();
    cnt_start = 1'b0; cnt_stop = 1'b0;
  endtask

  task automatic write(input logic [63:0] d);
    tohost_valid = 1'b1; tohost_data = d;
    step();
    tohost_valid = 1'b0;
  endtask

  task automatic stop_and_check(input string name, input logic [63:0] exp);
    rt_sb.push_back(exp);
    pulse(1'b0, 1'b1);
    chk(name, runtime, rt_sb.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   got;
    //            pre   data                    idle mask  cycles tmo
    vecs[0] = '{1'b0, 64'h1,                  16'hFFFF, 2,  1'b0};
    vecs[1] = '{1'b1, 64'hB,                  16'hFFFF, 2,  1'b0};
    vecs[2] = '{1'b0, 64'h7,                  16'h0000, 16, 1'b1};
    vecs[3] = '{1'b0, 64'h9,                  16'h000D, 4,  1'b0};
    vecs[4] = '{1'b0, 64'h21,                 16'hC000, 16, 1'b0};
    vecs[5] = '{1'b0, 64'h41,                 16'h8000, 16, 1'b1};
    vecs[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 2,  1'b0};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      chk("rst_exit", exit_w, 64'h0);
      chk("rst_timeout", {63'b0, timeout}, 64'h0);
      chk("rst_ready", {63'b0, tohost_ready}, 64'h1);
      if (vecs[i].pre) begin
        write(64'h10);
        chk("pre_ready", {63'b0, tohost_ready}, 64'h1);
        chk("pre_exit", exit_w, 64'h0);
      end
      sb.push_back('{vecs[i].data, vecs[i].tmo, vecs[i].cycles});
      write(vecs[i].data);
      chk("drain_ready", {63'b0, tohost_ready}, 64'h0);
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        ara_idle = (k < 16) ? vecs[i].mask[k] : 1'b0;
        step();
        if (exit_w[0]) begin
          got = 1'b1;
          e = sb.pop_front();
          chk("exit_word", exit_w, e.exit_word);
          chk("exit_timeout", {63'b0, timeout}, {63'b0, e.tmo});
          chk("drain_cycles", 64'(k + 1), 64'(e.cycles));
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL exit_wait actual=no_exit expected=exit vec=%0d", i);
        void'(sb.pop_front());
      end else begin
        write(64'h3);
        step();
        chk("exit_hold", exit_w, e.exit_word);
        chk("exit_ready", {63'b0, tohost_ready}, 64'h0);
      end
    end

    // Runtime measurement sequences
    do_reset();
    chk("rt_rst_valid", {63'b0, runtime_valid}, 64'h0);
    chk("rt_rst_val", runtime, 64'h0);
    pulse(1'b1, 1'b0);
    repeat (99) step();
    stop_and_check("rt_100", 64'd100);
    chk("rt_valid", {63'b0, runtime_valid}, 64'h1);
    repeat (9) step();
    pulse(1'b0, 1'b1);
    chk("rt_stray_stop", runtime, 64'd100);
    pulse(1'b1, 1'b0);
    repeat (49) step();
    rt_sb.push_back(64'd50);
    pulse(1'b1, 1'b1);
    chk("rt_both_active", runtime, rt_sb.pop_front());
    repeat (29) step();
    stop_and_check("rt_after_restart", 64'd30);
    pulse(1'b1, 1'b1);
    repeat (9) step();
    stop_and_check("rt_both_idle", 64'd10);
    pulse(1'b1, 1'b0);
    repeat (19) step();
    pulse(1'b1, 1'b0);
    repeat (4) step();
    stop_and_check("rt_restart", 64'd5);

    // Entering EXIT kills an active measurement
    pulse(1'b1, 1'b0);
    repeat (3) step();
    ara_idle = 1'b1;
    write(64'h1);
    step(); step();
    chk("rt_exit_word", exit_w, 64'h1);
    pulse(1'b0, 1'b1);
    chk("rt_exit_nolatch", runtime, 64'd5);
    pulse(1'b1, 1'b0);
    repeat (3) step();
    pulse(1'b0, 1'b1);
    chk("rt_exit_ignored", runtime, 64'd5);

    // Async reset mid-drain and mid-measurement
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (10) step();
    stop_and_check("rt_pre_rst", 64'd11);
    pulse(1'b1, 1'b0);
    ara_idle = 1'b0;
    write(64'h7);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_exit", exit_w, 64'h0);
    chk("arst_timeout", {63'b0, timeout}, 64'h0);
    chk("arst_runtime", runtime, 64'h0);
    chk("arst_rvalid", {63'b0, runtime_valid}, 64'h0);
    chk("arst_ready", {63'b0, tohost_ready}, 64'h1);
    #1 rst_n = 1'b1;
    step();
    ara_idle = 1'b1;
    write(64'h3);
    step();
    chk("post_rst_drain", exit_w, 64'h0);
    step();
    chk("post_rst_exit", exit_w, 64'h3);
    chk("post_rst_timeout", {63'b0, timeout}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
